// File: rtl/uart_rx_frame_pkg.sv
// uart_rx_frame_pkg: receiver FSM state encoding and bit-timer width helper
package uart_rx_frame_pkg;
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    // Timer width for a given bit period; at least one bit so the counter always exists.
    function automatic int cnt_w(input int cpb);
        return cpb > 1 ? $clog2(cpb) : 1;
    endfunction
endpackage

// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: serial line in, decoded frame fields and status pulses out
//   in                        serial line, idle high (master drives)
//   dado / instrucao          fields of the last good frame
//   frame_valid/err, parity_err  one-cycle status pulses
//   busy, uat                 receiver active flag, registered copy of in
interface uart_rx_frame_if #(
    parameter int DATA_W  = 4,
    parameter int INSTR_W = 4
);
    logic               in;
    logic [DATA_W-1:0]  dado;
    logic [INSTR_W-1:0] instrucao;
    logic               frame_valid;
    logic               frame_err;
    logic               parity_err;
    logic               busy;
    logic               uat;

    modport master (output in, input dado, instrucao, frame_valid, frame_err, parity_err, busy, uat);
    modport slave  (input in, output dado, instrucao, frame_valid, frame_err, parity_err, busy, uat);
endinterface

// File: rtl/uart_rx_frame_bit_timer.sv
// uart_rx_frame_bit_timer: bit-period down-counter with load and zero flag
//   clock, resetn  system clock, synchronous active-low reset
//   load, lval     load lval into the counter (priority over decrement)
//   zero           counter is zero; the FSM acts only on this cycle
module uart_rx_frame_bit_timer import uart_rx_frame_pkg::*; #(
    parameter int CLKS_PER_BIT = 1,
    localparam int CW = cnt_w(CLKS_PER_BIT)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          load,
    input  logic [CW-1:0] lval,
    output logic          zero
);
    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (!resetn)
            cnt <= '0;
        else if (load)
            cnt <= lval;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = cnt == '0;
endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: serial command-frame receiver (start, data, instr, opt. parity, stop)
//   clock, resetn  system clock, synchronous active-low reset
//   bus            slave side of uart_rx_frame_if (serial in, fields, status pulses)
module uart_rx_frame import uart_rx_frame_pkg::*; #(
    parameter int DATA_W       = 4,
    parameter int INSTR_W      = 4,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input logic            clock,
    input logic            resetn,
    uart_rx_frame_if.slave bus
);
    localparam int NB     = DATA_W + INSTR_W;
    localparam int IW     = $clog2(NB);
    localparam int CW     = cnt_w(CLKS_PER_BIT);
    localparam int HALF_I = CLKS_PER_BIT > 1 ? CLKS_PER_BIT / 2 - 1 : 0;
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(HALF_I);

    state_t             state, state_n;
    logic [IW-1:0]      idx;
    logic [NB-1:0]      sr;
    logic               par_bad;
    logic [DATA_W-1:0]  dado;
    logic [INSTR_W-1:0] instrucao;
    logic               frame_valid, frame_err, parity_err, uat;
    logic               load, zero, shift, pchk, good, ferr, perr, last;
    logic [CW-1:0]      lval;

    uart_rx_frame_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) timer (
        .clock (clock),
        .resetn(resetn),
        .load  (load),
        .lval  (lval),
        .zero  (zero)
    );

    assign last = idx == IW'(NB - 1);

    always_comb begin
        state_n = state;
        load    = 1'b0;
        lval    = FULL;
        shift   = 1'b0;
        pchk    = 1'b0;
        good    = 1'b0;
        ferr    = 1'b0;
        perr    = 1'b0;
        case (state)
            IDLE: if (!bus.in) begin
                // One clock per bit: the start edge itself is the start bit, go straight to data.
                state_n = CLKS_PER_BIT == 1 ? DATA : START;
                load    = 1'b1;
                lval    = CLKS_PER_BIT == 1 ? '0 : HALF;
            end
            START: if (zero) begin
                state_n = bus.in ? IDLE : DATA;
                load    = 1'b1;
            end
            DATA: if (zero) begin
                shift = 1'b1;
                load  = 1'b1;
                if (last) state_n = PARITY_EN != 0 ? PARITY : STOP;
            end
            PARITY: if (zero) begin
                pchk    = 1'b1;
                load    = 1'b1;
                state_n = STOP;
            end
            STOP: if (zero) begin
                state_n = bus.in ? IDLE : WAIT_HIGH;
                good    = bus.in & ~par_bad;
                perr    = bus.in & par_bad;
                ferr    = ~bus.in;
            end
            WAIT_HIGH: if (bus.in) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= IDLE;
            idx         <= '0;
            sr          <= '0;
            par_bad     <= 1'b0;
            dado        <= '0;
            instrucao   <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            uat         <= 1'b1;
        end else begin
            state       <= state_n;
            uat         <= bus.in;
            frame_valid <= good;
            frame_err   <= ferr;
            parity_err  <= perr;
            // LSB-first line: shift right so bit 0 ends up at sr[0] after NB bits.
            if (shift) begin
                sr  <= {bus.in, sr[NB-1:1]};
                idx <= last ? '0 : idx + 1'b1;
            end
            if (pchk)
                par_bad <= (^{sr, bus.in}) != (PARITY_ODD != 0);
            else if (state == IDLE)
                par_bad <= 1'b0;
            if (good) begin
                dado      <= sr[DATA_W-1:0];
                instrucao <= sr[NB-1:DATA_W];
            end
        end
    end

    assign bus.dado        = dado;
    assign bus.instrucao   = instrucao;
    assign bus.frame_valid = frame_valid;
    assign bus.frame_err   = frame_err;
    assign bus.parity_err  = parity_err;
    assign bus.busy        = state != IDLE;
    assign bus.uat         = uat;
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed tests for uart_rx_frame across three configurations
module tb_uart_rx_frame;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fv_cnt = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) if (b0.frame_valid) fv_cnt <= fv_cnt + 1;

    uart_rx_frame_if #(.DATA_W(4), .INSTR_W(4)) b0 ();
    uart_rx_frame_if #(.DATA_W(4), .INSTR_W(4)) b1 ();
    uart_rx_frame_if #(.DATA_W(4), .INSTR_W(4)) b2 ();

    uart_rx_frame #(.CLKS_PER_BIT(1)) dut0 (.clock(clock), .resetn(resetn), .bus(b0.slave));
    uart_rx_frame #(.CLKS_PER_BIT(16)) dut1 (.clock(clock), .resetn(resetn), .bus(b1.slave));
    uart_rx_frame #(.CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(0)) dut2 (.clock(clock), .resetn(resetn), .bus(b2.slave));

    // Set line w at the falling edge, return 1 time unit after the rising edge that samples it.
    task automatic drive(input int w, input logic v);
        @(negedge clock);
        if (w == 0) b0.in = v;
        else if (w == 1) b1.in = v;
        else b2.in = v;
        @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input int w, input logic [3:0] d, input logic [3:0] ins,
                              input logic usep, input logic p, input logic stop);
        drive(w, 1'b0);
        for (int i = 0; i < 4; i++) drive(w, d[i]);
        for (int i = 0; i < 4; i++) drive(w, ins[i]);
        if (usep) drive(w, p);
        drive(w, stop);
    endtask

    task automatic test_reset;
        b0.in = 1'b1; b1.in = 1'b1; b2.in = 1'b1;
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (b0.dado !== 4'h0) begin errors++; $display("FAIL reset_dado got %h want 0", b0.dado); end
        checks++; if (b0.instrucao !== 4'h0) begin errors++; $display("FAIL reset_instr got %h want 0", b0.instrucao); end
        checks++; if ({b0.frame_valid, b0.frame_err, b0.parity_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {b0.frame_valid, b0.frame_err, b0.parity_err}); end
        checks++; if (b0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", b0.busy); end
        checks++; if (b0.uat !== 1'b1) begin errors++; $display("FAIL reset_uat got %b want 1", b0.uat); end
        checks++; if (b2.busy !== 1'b0 || b1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy12 got %b%b want 00", b1.busy, b2.busy); end
        @(negedge clock) resetn = 1'b1;
        drive(0, 1'b1);
    endtask

    task automatic test_good_frame;
        logic [7:0] v;
        v = 8'h3A;
        drive(0, 1'b0);
        checks++; if (b0.busy !== 1'b1) begin errors++; $display("FAIL start_busy got %b want 1", b0.busy); end
        checks++; if (b0.uat !== 1'b0) begin errors++; $display("FAIL uat_copy got %b want 0", b0.uat); end
        for (int i = 0; i < 8; i++) begin
            drive(0, v[i]);
            checks++; if (b0.frame_valid !== 1'b0 || b0.busy !== 1'b1) begin errors++; $display("FAIL bit%0d_fv_busy got %b%b want 01", i, b0.frame_valid, b0.busy); end
        end
        drive(0, 1'b1);
        checks++; if (b0.frame_valid !== 1'b1) begin errors++; $display("FAIL stop_fv got %b want 1", b0.frame_valid); end
        checks++; if (b0.dado !== 4'hA) begin errors++; $display("FAIL good_dado got %h want a", b0.dado); end
        checks++; if (b0.instrucao !== 4'h3) begin errors++; $display("FAIL good_instr got %h want 3", b0.instrucao); end
        checks++; if (b0.frame_err !== 1'b0 || b0.busy !== 1'b0) begin errors++; $display("FAIL stop_ferr_busy got %b%b want 00", b0.frame_err, b0.busy); end
        drive(0, 1'b1);
        checks++; if (b0.frame_valid !== 1'b0) begin errors++; $display("FAIL fv_one_cycle got %b want 0", b0.frame_valid); end
    endtask

    task automatic test_frame_err;
        send_frame(0, 4'hA, 4'h3, 1'b0, 1'b0, 1'b0);
        checks++; if (b0.frame_err !== 1'b1 || b0.frame_valid !== 1'b0) begin errors++; $display("FAIL ferr_pulse got ferr=%b fv=%b want 1 0", b0.frame_err, b0.frame_valid); end
        checks++; if (b0.busy !== 1'b1) begin errors++; $display("FAIL ferr_busy got %b want 1", b0.busy); end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b0);
            checks++; if (b0.busy !== 1'b1 || b0.frame_err !== 1'b0) begin errors++; $display("FAIL wait_high%0d got busy=%b ferr=%b want 1 0", i, b0.busy, b0.frame_err); end
        end
        drive(0, 1'b1);
        checks++; if (b0.busy !== 1'b0) begin errors++; $display("FAIL wait_release got %b want 0", b0.busy); end
        checks++; if (b0.dado !== 4'hA || b0.instrucao !== 4'h3) begin errors++; $display("FAIL ferr_hold got %h%h want a3", b0.dado, b0.instrucao); end
        drive(0, 1'b1);
    endtask

    task automatic test_glitch;
        for (int c = 1; c <= 12; c++) begin
            drive(1, c <= 4 ? 1'b0 : 1'b1);
            checks++; if ({b1.frame_valid, b1.frame_err, b1.parity_err} !== 3'b000) begin errors++; $display("FAIL glitch_pulse%0d got %b want 000", c, {b1.frame_valid, b1.frame_err, b1.parity_err}); end
            if (c == 8) begin
                checks++; if (b1.busy !== 1'b1) begin errors++; $display("FAIL glitch_busy8 got %b want 1", b1.busy); end
            end
            if (c == 9) begin
                checks++; if (b1.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy9 got %b want 0", b1.busy); end
            end
        end
    endtask

    task automatic test_parity;
        drive(2, 1'b1);
        send_frame(2, 4'h1, 4'h0, 1'b1, 1'b0, 1'b1);
        checks++; if (b2.parity_err !== 1'b1 || b2.frame_valid !== 1'b0) begin errors++; $display("FAIL par_bad got perr=%b fv=%b want 1 0", b2.parity_err, b2.frame_valid); end
        checks++; if (b2.dado !== 4'h0) begin errors++; $display("FAIL par_hold got %h want 0", b2.dado); end
        drive(2, 1'b1);
        checks++; if (b2.parity_err !== 1'b0) begin errors++; $display("FAIL perr_one_cycle got %b want 0", b2.parity_err); end
        send_frame(2, 4'h1, 4'h0, 1'b1, 1'b1, 1'b1);
        checks++; if (b2.frame_valid !== 1'b1 || b2.parity_err !== 1'b0) begin errors++; $display("FAIL par_good got fv=%b perr=%b want 1 0", b2.frame_valid, b2.parity_err); end
        checks++; if (b2.dado !== 4'h1 || b2.instrucao !== 4'h0) begin errors++; $display("FAIL par_fields got %h%h want 10", b2.dado, b2.instrucao); end
        drive(2, 1'b1);
    endtask

    task automatic test_back_to_back;
        int t1, n0;
        n0 = fv_cnt;
        send_frame(0, 4'h5, 4'h9, 1'b0, 1'b0, 1'b1);
        t1 = cyc;
        checks++; if (b0.frame_valid !== 1'b1 || b0.dado !== 4'h5 || b0.instrucao !== 4'h9) begin errors++; $display("FAIL b2b_first got fv=%b %h%h want 1 59", b0.frame_valid, b0.dado, b0.instrucao); end
        send_frame(0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1);
        checks++; if (b0.frame_valid !== 1'b1 || b0.dado !== 4'hF || b0.instrucao !== 4'h0) begin errors++; $display("FAIL b2b_second got fv=%b %h%h want 1 f0", b0.frame_valid, b0.dado, b0.instrucao); end
        checks++; if (cyc - t1 !== 10) begin errors++; $display("FAIL b2b_gap got %0d want 10", cyc - t1); end
        drive(0, 1'b1);
        drive(0, 1'b1);
        checks++; if (fv_cnt - n0 !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", fv_cnt - n0); end
    endtask

    task automatic test_mid_reset;
        drive(0, 1'b0);
        drive(0, 1'b0);
        drive(0, 1'b1);
        drive(0, 1'b1);
        @(negedge clock);
        resetn = 1'b0;
        b0.in = 1'b1;
        @(posedge clock);
        #1;
        checks++; if (b0.dado !== 4'h0 || b0.instrucao !== 4'h0) begin errors++; $display("FAIL mrst_fields got %h%h want 00", b0.dado, b0.instrucao); end
        checks++; if (b0.busy !== 1'b0 || b0.uat !== 1'b1) begin errors++; $display("FAIL mrst_busy_uat got %b%b want 01", b0.busy, b0.uat); end
        checks++; if ({b0.frame_valid, b0.frame_err, b0.parity_err} !== 3'b000) begin errors++; $display("FAIL mrst_pulses got %b want 000", {b0.frame_valid, b0.frame_err, b0.parity_err}); end
        @(negedge clock) resetn = 1'b1;
        drive(0, 1'b1);
        send_frame(0, 4'h6, 4'hC, 1'b0, 1'b0, 1'b1);
        checks++; if (b0.frame_valid !== 1'b1 || b0.dado !== 4'h6 || b0.instrucao !== 4'hC) begin errors++; $display("FAIL mrst_frame got fv=%b %h%h want 1 6c", b0.frame_valid, b0.dado, b0.instrucao); end
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_frame_err;
        test_glitch;
        test_parity;
        test_back_to_back;
        test_mid_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
